// File: rtl/tara_ctrl.sv
// ---------------------------------------------------------------------------
// tara_ctrl
//
// Tare sequencing controller between the ADC sample interface and the
// display/BCD stage. Loads the default tare word after reset, acquires an
// averaged tare on request, reverts to the default on clear, and produces a
// registered net weight (gross - tare, clamped at zero) together with an
// underflow flag and a stability flag.
//
// Ports
//   clk           system clock, all logic on rising edge
//   rst_n         synchronous active-low reset
//   tara_default  default tare word from the tara block
//   sample        raw gross weight sample
//   sample_valid  one-cycle qualifier for sample
//   tare_req      one-cycle pulse: acquire a new averaged tare
//   tare_clear    one-cycle pulse: revert to tara_default (wins over tare_req)
//   net_weight    gross - tare, clamped at 0
//   net_valid     one-cycle pulse, net_weight/negative/stable updated
//   negative      gross < tare on the last valid sample
//   stable        STABLE_CNT consecutive in-band sample deltas seen
//   tare_busy     high while acquiring or committing a tare
//   tare_value    tare currently applied
// ---------------------------------------------------------------------------
module tara_ctrl #(
  parameter int W          = 12,
  parameter int AVG_LOG2   = 2,
  parameter int BAND       = 4,
  parameter int STABLE_CNT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] tara_default,
  input  logic [W-1:0] sample,
  input  logic         sample_valid,
  input  logic         tare_req,
  input  logic         tare_clear,
  output logic [W-1:0] net_weight,
  output logic         net_valid,
  output logic         negative,
  output logic         stable,
  output logic         tare_busy,
  output logic [W-1:0] tare_value
);

  localparam int ACC_W  = W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int SCNT_W = $clog2(STABLE_CNT + 1);

  // Counter value at which the final sample of an acquisition is being added.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(2 ** AVG_LOG2 - 1);
  localparam logic [SCNT_W-1:0] STAB_MAX  = SCNT_W'(STABLE_CNT);
  localparam logic [W-1:0]      BAND_W    = W'(BAND);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    ACQ    = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e              state_q;
  logic [W-1:0]        tare_value_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [W-1:0]        prev_q;
  logic                have_prev_q;
  logic [SCNT_W-1:0]   stab_cnt_q;
  logic [W-1:0]        net_weight_q;
  logic                net_valid_q;
  logic                negative_q;
  logic                stable_q;
  logic                tare_busy_q;

  logic [W-1:0]        net_d;
  logic                negative_d;
  logic [W-1:0]        delta;
  logic [SCNT_W-1:0]   stab_cnt_d;
  logic [ACC_W-1:0]    acc_d;
  logic                take_sample;

  // Net result, sample delta and stability counter candidates for the sample
  // currently on the bus; committed only when the sample is taken.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    net_d      = '0;
    negative_d = 1'b0;
    stab_cnt_d = stab_cnt_q;

    if (sample >= tare_value_q) begin
      net_d = sample - tare_value_q;
    end else begin
      negative_d = 1'b1;
    end

    delta = (sample >= prev_q) ? (sample - prev_q) : (prev_q - sample);

    // The very first sample after reset has nothing to compare against.
    if (have_prev_q) begin
      if (delta <= BAND_W) begin
        if (stab_cnt_q != STAB_MAX) begin
          stab_cnt_d = stab_cnt_q + SCNT_W'(1);
        end
      end else begin
        stab_cnt_d = '0;
      end
    end

    acc_d       = acc_q + ACC_W'(sample);
    take_sample = sample_valid && (state_q != LOAD);
  end

  // NOTE: synchronous reset lives inside the clocked block; all state uses
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      tare_value_q <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      stab_cnt_q   <= '0;
      net_weight_q <= '0;
      net_valid_q  <= 1'b0;
      negative_q   <= 1'b0;
      stable_q     <= 1'b0;
      tare_busy_q  <= 1'b0;
    end else begin
      net_valid_q <= 1'b0;

      // Net path runs in every state but LOAD and always uses the tare held
      // before this edge, so a COMMIT-cycle sample still sees the old tare.
      if (take_sample) begin
        net_valid_q  <= 1'b1;
        net_weight_q <= net_d;
        negative_q   <= negative_d;
        prev_q       <= sample;
        have_prev_q  <= 1'b1;
        stab_cnt_q   <= stab_cnt_d;
        stable_q     <= (stab_cnt_d == STAB_MAX);
      end

      case (state_q)
        LOAD: begin
          tare_value_q <= tara_default;
          state_q      <= RUN;
        end

        RUN: begin
          // Clear has priority: a coincident request starts nothing.
          if (tare_clear) begin
            tare_value_q <= tara_default;
          end else if (tare_req) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            tare_busy_q <= 1'b1;
            state_q     <= ACQ;
          end
        end

        ACQ: begin
          if (tare_clear) begin
            tare_value_q <= tara_default;
            tare_busy_q  <= 1'b0;
            state_q      <= RUN;
          end else if (sample_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= COMMIT;
            end
          end
        end

        COMMIT: begin
          // Truncating average: drop the AVG_LOG2 fractional bits.
          tare_value_q <= acc_q[ACC_W-1:AVG_LOG2];
          tare_busy_q  <= 1'b0;
          state_q      <= RUN;
        end

        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign net_weight = net_weight_q;
  assign net_valid  = net_valid_q;
  assign negative   = negative_q;
  assign stable     = stable_q;
  assign tare_busy  = tare_busy_q;
  assign tare_value = tare_value_q;

endmodule

// File: tb/tb_tara_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tara_ctrl
//
// Directed scenarios followed by randomized traffic. The driver advances a
// behavioural model of the tare/net/stability rules each cycle, checks the
// tare register and busy flag directly, and queues the expected net result
// for every accepted sample. A monitor pops the queue on each net_valid.
// ---------------------------------------------------------------------------
module tb_tara_ctrl;

  localparam int W          = 12;
  localparam int AVG_LOG2   = 2;
  localparam int BAND       = 4;
  localparam int STABLE_CNT = 8;
  localparam int AVG_N      = 1 << AVG_LOG2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] tara_default;
  logic [W-1:0] sample;
  logic         sample_valid;
  logic         tare_req;
  logic         tare_clear;
  logic [W-1:0] net_weight;
  logic         net_valid;
  logic         negative;
  logic         stable;
  logic         tare_busy;
  logic [W-1:0] tare_value;

  tara_ctrl #(
    .W(W), .AVG_LOG2(AVG_LOG2), .BAND(BAND), .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tara_default (tara_default),
    .sample       (sample),
    .sample_valid (sample_valid),
    .tare_req     (tare_req),
    .tare_clear   (tare_clear),
    .net_weight   (net_weight),
    .net_valid    (net_valid),
    .negative     (negative),
    .stable       (stable),
    .tare_busy    (tare_busy),
    .tare_value   (tare_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int net;
    int neg;
    int stb;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, in terms of the documented behaviour.
  int m_tare;
  bit m_loading;
  bit m_acq;
  bit m_commit;
  int m_acq_s[$];
  int m_prev;
  bit m_have_prev;
  int m_stab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every net_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (net_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_net_valid: got net_valid=1 expected no result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("net_weight", 32'(net_weight), e.net);
        check("negative",   32'(negative),   e.neg);
        check("stable",     32'(stable),     e.stb);
      end
    end
  end

  // One clock of stimulus; called right after a falling edge.
  task automatic cycle(input bit v, input int s, input bit rq, input bit cl);
    sample_valid = v;
    sample       = W'(s);
    tare_req     = rq;
    tare_clear   = cl;

    if (m_loading) begin
      m_tare    = int'(tara_default);
      m_loading = 1'b0;
    end else begin
      if (v) begin
        exp_t e;
        if (s >= m_tare) begin
          e.net = s - m_tare;
          e.neg = 0;
        end else begin
          e.net = 0;
          e.neg = 1;
        end
        if (m_have_prev) begin
          int d;
          d = (s > m_prev) ? s - m_prev : m_prev - s;
          if (d <= BAND) m_stab = (m_stab < STABLE_CNT) ? m_stab + 1 : STABLE_CNT;
          else           m_stab = 0;
        end
        m_prev      = s;
        m_have_prev = 1'b1;
        e.stb       = (m_stab == STABLE_CNT) ? 1 : 0;
        sb_q.push_back(e);
      end

      if (m_commit) begin
        int sum;
        sum = 0;
        foreach (m_acq_s[i]) sum += m_acq_s[i];
        m_tare   = sum / AVG_N;
        m_commit = 1'b0;
      end else if (m_acq) begin
        if (cl) begin
          m_tare = int'(tara_default);
          m_acq  = 1'b0;
        end else if (v) begin
          m_acq_s.push_back(s);
          if (m_acq_s.size() == AVG_N) begin
            m_acq    = 1'b0;
            m_commit = 1'b1;
          end
        end
      end else begin
        if (cl) begin
          m_tare = int'(tara_default);
        end else if (rq) begin
          m_acq = 1'b1;
          m_acq_s.delete();
        end
      end
    end

    @(posedge clk);
    #1;
    check("tare_value", 32'(tare_value), m_tare);
    check("tare_busy",  32'(tare_busy),  (m_acq || m_commit) ? 1 : 0);
    @(negedge clk);
    sample_valid = 1'b0;
    tare_req     = 1'b0;
    tare_clear   = 1'b0;
  endtask

  // Hold reset for n edges, checking every output is cleared on each edge.
  task automatic do_reset(input int n);
    rst_n        = 1'b0;
    m_tare       = 0;
    m_loading    = 1'b1;
    m_acq        = 1'b0;
    m_commit     = 1'b0;
    m_have_prev  = 1'b0;
    m_stab       = 0;
    m_prev       = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_net_weight", 32'(net_weight), 0);
      check("rst_net_valid",  32'(net_valid),  0);
      check("rst_negative",   32'(negative),   0);
      check("rst_stable",     32'(stable),     0);
      check("rst_tare_busy",  32'(tare_busy),  0);
      check("rst_tare_value", 32'(tare_value), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int s;
    int stab_seq[9] = '{1000, 1002, 999, 1003, 1000, 1004, 1001, 1000, 1002};
    int acq_seq[4]  = '{500, 502, 498, 500};

    rst_n        = 1'b0;
    tara_default = W'(300);
    sample       = '0;
    sample_valid = 1'b0;
    tare_req     = 1'b0;
    tare_clear   = 1'b0;

    @(negedge clk);
    do_reset(3);

    // LOAD cycle: tare_value becomes the default one edge after release.
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 1000, 1'b0, 1'b0);   // net 700
    cycle(1'b1, 200,  1'b0, 1'b0);   // clamp, negative
    cycle(1'b1, 301,  1'b0, 1'b0);   // net 1

    // Averaged tare acquisition; samples during ACQ/COMMIT use the old tare.
    cycle(1'b0, 0, 1'b1, 1'b0);
    foreach (acq_seq[i]) cycle(1'b1, acq_seq[i], 1'b0, 1'b0);
    cycle(1'b1, 800, 1'b0, 1'b0);    // COMMIT cycle, tare still 300
    cycle(1'b1, 750, 1'b0, 1'b0);    // net 250 with tare 500

    // Abort an acquisition with tare_clear.
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 510, 1'b0, 1'b0);
    cycle(1'b1, 512, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Coincident request and clear: nothing starts.
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 700, 1'b0, 1'b0);

    // Stability ramp then an out-of-band step.
    foreach (stab_seq[i]) cycle(1'b1, stab_seq[i], 1'b0, 1'b0);
    cycle(1'b1, 1020, 1'b0, 1'b0);

    // Reset in the middle of an acquisition, new default during reset.
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 600, 1'b0, 1'b0);
    cycle(1'b1, 601, 1'b0, 1'b0);
    tara_default = W'(450);
    do_reset(2);
    cycle(1'b0, 0, 1'b0, 1'b0);      // LOAD picks up 450
    cycle(1'b1, 900, 1'b0, 1'b0);    // RUN: net 450
    cycle(1'b1, 100, 1'b0, 1'b0);

    // Randomized traffic.
    base = 1500;
    for (int c = 0; c < 700; c++) begin
      bit v, rq, cl;
      if ($urandom_range(0, 39) == 0) base = $urandom_range(0, (1 << W) - 1);
      if ($urandom_range(0, 49) == 0) tara_default = W'($urandom_range(0, (1 << W) - 1));
      s = base + $urandom_range(0, 2 * BAND + 2) - (BAND + 1);
      if (s < 0) s = 0;
      if (s > (1 << W) - 1) s = (1 << W) - 1;
      v  = ($urandom_range(0, 3) != 0);
      rq = ($urandom_range(0, 24) == 0);
      cl = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        cycle(v, s, rq, cl);
      end
    end

    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
